instr_fetch_unit: RTL and testbench

- Front end of the RISC-V core, directly upstream of the controller.
- Owns the PC register and runs a request/response handshake with instruction memory.
- Presents the fetched instruction, plus its pre-sliced op/funct3/funct7b5 fields, to the controller and datapath.
- On each retire, computes the next PC from the controller's PCSrc/Jalr outputs and the datapath's ImmExt/ALUResult, then fetches again.

---
 rtl/instr_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC and runs the request/response fetch handshake
// with instruction memory. It presents the held instruction and its decoded
// fields to the controller, then steps the PC when an instruction retires.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        retire,
    input  logic        PCSrc,
    input  logic        Jalr,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic        fetch_fault
);
    localparam logic [31:0] NOP       = 32'h0000_0013;
    // Last WAIT count value before giving up; WAIT ends after TIMEOUT silent cycles.
    localparam logic [3:0]  WAIT_LAST = 4'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_VALID, S_FAULT} state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic [31:0] pc_target;
    logic        capture;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign op        = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7b5  = instr[30];

    // A response is taken either together with acceptance or later while waiting.
    assign capture = ((state == S_REQ) && imem_ready && imem_rvalid)
                  || ((state == S_WAIT) && imem_rvalid);

    // Next-PC selection on retire: jalr over branch/jal over sequential.
    always_comb begin
        if (Jalr)
            pc_target = ALUResult & ~32'd1;
        else if (PCSrc)
            pc_target = pc + ImmExt;
        else
            pc_target = pc_plus4;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  state_next = S_REQ;
            S_REQ: begin
                if (imem_ready && imem_rvalid)
                    state_next = S_VALID;
                else if (imem_ready)
                    state_next = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid)
                    state_next = S_VALID;
                else if (wait_cnt == WAIT_LAST)
                    state_next = S_FAULT;
            end
            S_VALID: begin
                if (retire)
                    state_next = pc_target[1] ? S_FAULT : S_REQ;
            end
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        imem_req    = (state == S_REQ);
        instr_valid = (state == S_VALID);
        fetch_fault = (state == S_FAULT);
    end

    // PC, instruction holding register and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            instr    <= NOP;
            wait_cnt <= '0;
        end else begin
            if (state_next == S_FAULT)
                instr <= NOP;
            else if (capture)
                instr <= imem_rdata;

            if (state == S_REQ)
                wait_cnt <= '0;
            else if (state == S_WAIT)
                wait_cnt <= wait_cnt + 4'd1;

            if ((state == S_VALID) && retire && !pc_target[1])
                pc <= pc_target;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: bench acting as instruction memory and retire source,
// checking the fetch unit against an architectural PC/instruction model.
module tb_instr_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        retire;
    logic        PCSrc;
    logic        Jalr;
    logic [31:0] ImmExt;
    logic [31:0] ALUResult;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        fetch_fault;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [31:0] exp_pc;
    logic        faulted;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .retire(retire), .PCSrc(PCSrc), .Jalr(Jalr), .ImmExt(ImmExt), .ALUResult(ALUResult),
        .pc(pc), .pc_plus4(pc_plus4), .instr(instr), .instr_valid(instr_valid),
        .op(op), .funct3(funct3), .funct7b5(funct7b5), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Memory contents: fixed word at 0, address hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic idle_inputs();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        retire      = 1'($urandom_range(0, 1));
        PCSrc       = 1'($urandom_range(0, 1));
        Jalr        = 1'($urandom_range(0, 1));
        ImmExt      = $urandom;
        ALUResult   = $urandom;
    endtask

    task automatic check_faulted(input string tag);
        check({tag, "_fault"}, fetch_fault, 1'b1);
        check({tag, "_req"},   imem_req,    1'b0);
        check({tag, "_valid"}, instr_valid, 1'b0);
        check({tag, "_instr"}, instr,       NOP);
        check({tag, "_pc"},    pc,          exp_pc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check("rst_pc",    pc,          32'h0);
        check("rst_req",   imem_req,    1'b0);
        check("rst_instr", instr,       NOP);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_fault", fetch_fault, 1'b0);
        exp_pc  = 32'h0;
        faulted = 1'b0;
        @(negedge clk);
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rst_stray_rvalid", instr, NOP);
        check("rst_op", {25'd0, op}, 32'h13);
        idle_inputs();
    endtask

    // Serve one fetch: stall cycles with ready low, then accept; lat=0 is zero-wait.
    task automatic fetch(input int unsigned lat, input int unsigned stall);
        logic [31:0] w;
        w = mem_word(exp_pc);
        check("req", imem_req, 1'b1);
        check("addr", imem_addr, exp_pc);
        for (int i = 0; i < int'(stall); i++) begin
            imem_ready  = 1'b0;
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            @(negedge clk);
            check("stall_addr", imem_addr, exp_pc);
            check("stall_valid", instr_valid, 1'b0);
        end
        imem_ready  = 1'b1;
        imem_rvalid = (lat == 0);
        imem_rdata  = (lat == 0) ? w : $urandom;
        @(negedge clk);
        if (lat != 0) begin
            idle_inputs();
            check("wait_req", imem_req, 1'b0);
            for (int i = 1; i < int'(lat); i++) begin
                idle_inputs();
                retire = 1'b1;
                imem_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            check("wait_valid", instr_valid, 1'b0);
            imem_rvalid = 1'b1;
            imem_rdata  = w;
            @(negedge clk);
        end
        idle_inputs();
        retire = 1'b0;
        check("valid", instr_valid, 1'b1);
        check("instr", instr, w);
        check("op", {25'd0, op}, {25'd0, w[6:0]});
        check("funct3", {29'd0, funct3}, {29'd0, w[14:12]});
        check("funct7b5", {31'd0, funct7b5}, {31'd0, w[30]});
        check("pc", pc, exp_pc);
        check("pc_plus4", pc_plus4, exp_pc + 32'd4);
    endtask

    task automatic do_retire(input int unsigned hold, input logic jr, input logic br,
                             input logic [31:0] imm, input logic [31:0] alu);
        logic [31:0] nxt;
        for (int i = 0; i < int'(hold); i++) begin
            idle_inputs();
            retire = 1'b0;
            @(negedge clk);
            check("hold_instr", instr, mem_word(exp_pc));
            check("hold_valid", instr_valid, 1'b1);
        end
        retire = 1'b1; Jalr = jr; PCSrc = br; ImmExt = imm; ALUResult = alu;
        if (jr)      nxt = {alu[31:1], 1'b0};
        else if (br) nxt = exp_pc + imm;
        else         nxt = exp_pc + 32'd4;
        @(negedge clk);
        idle_inputs();
        if (nxt[1]) begin
            faulted = 1'b1;
            check_faulted("misalign");
        end else begin
            exp_pc = nxt;
            check("ret_valid", instr_valid, 1'b0);
            check("ret_req", imem_req, 1'b1);
            check("ret_addr", imem_addr, nxt);
        end
    endtask

    task automatic fault_hold();
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            imem_ready  = 1'b1;
            imem_rvalid = 1'b1;
            @(negedge clk);
            check_faulted("fault_hold");
        end
    endtask

    function automatic logic [31:0] rand_even(input int unsigned mis_pct);
        logic [31:0] v;
        v = $urandom & ~32'd3;
        if ($urandom_range(0, 99) < mis_pct) v = v | 32'd2;
        return v;
    endfunction

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        faulted = 1'b0;
        exp_pc = '0;

        // Zero-wait fetch at reset PC, sequential retire.
        do_reset();
        fetch(0, 0);
        do_retire(1, 1'b0, 1'b0, 32'h0, 32'h0);
        // Three-cycle memory with retire held high while waiting.
        fetch(3, 1);
        // Branch backwards from 0x100, then jalr winning over branch.
        do_retire(0, 1'b1, 1'b0, 32'h0, 32'h0000_0100);
        fetch(0, 0);
        do_retire(2, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0);
        check("branch_target", exp_pc, 32'h0000_00F0);
        fetch(2, 0);
        do_retire(0, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_0205);
        check("jalr_target", exp_pc, 32'h0000_0204);
        fetch(0, 0);

        // Misaligned branch target faults and stays faulted.
        do_reset();
        fetch(0, 0);
        do_retire(0, 1'b0, 1'b1, 32'h0000_0006, 32'h0);
        fault_hold();

        // Timeout: silent for 14 cycles is fine, the 15th faults.
        do_reset();
        check("to_req", imem_req, 1'b1);
        imem_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            idle_inputs();
            @(negedge clk);
        end
        check("to_before", fetch_fault, 1'b0);
        idle_inputs();
        @(negedge clk);
        check_faulted("timeout");
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(32'h0);
        @(negedge clk);
        check_faulted("late_rvalid");

        // Reset in the middle of a wait at 0x40, then PC wrap.
        do_reset();
        fetch(0, 0);
        do_retire(0, 1'b1, 1'b0, 32'h0, 32'h0000_0040);
        imem_ready = 1'b1;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        do_reset();
        fetch(0, 0);
        do_retire(0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFD);
        fetch(1, 0);
        do_retire(0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("wrap", imem_addr, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            int unsigned lat;
            lat = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : $urandom_range(0, 2);
            fetch(lat, $urandom_range(0, 2));
            do_retire($urandom_range(0, 2), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 1)), rand_even(12), $urandom & ~32'd2 | (32'($urandom_range(0, 9) == 0) << 1));
            if (faulted) begin
                fault_hold();
                do_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
